// File: rtl/gesture_path_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : gesture_path_gen_if
// Description : Control and coordinate bundle between a path requester and
//               the synthetic hand-trajectory generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface gesture_path_gen_if;
  logic        start;
  logic [1:0]  mode;
  logic        abort;
  logic [15:0] x1;
  logic [15:0] y1;
  logic [15:0] x2;
  logic [15:0] y2;
  logic        busy;
  logic        done;
  logic [2:0]  waypoint;

  // Requester side: issues start/abort, consumes the trajectory
  modport master (
    output start, mode, abort,
    input  x1, y1, x2, y2, busy, done, waypoint
  );

  // Generator side
  modport slave (
    input  start, mode, abort,
    output x1, y1, x2, y2, busy, done, waypoint
  );
endinterface
`default_nettype wire

// File: rtl/gesture_path_gen.sv
`default_nettype none
// ============================================================================
// Module      : gesture_path_gen
// Description : Plays a scripted two-hand path across the five vertical
//               screen strips, holding each waypoint for DWELL cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module gesture_path_gen #(
  parameter int MAX_X = 15,
  parameter int MAX_Y = 15,
  parameter int DWELL = 4
) (
  input wire logic           clock,
  input wire logic           reset,
  gesture_path_gen_if.slave  bus
);

  // Strip centres and the two vertical levels, all from integer division
  localparam logic [15:0] c_X0     = 16'((1 * MAX_X) / 10);
  localparam logic [15:0] c_X1     = 16'((3 * MAX_X) / 10);
  localparam logic [15:0] c_X2     = 16'((5 * MAX_X) / 10);
  localparam logic [15:0] c_X3     = 16'((7 * MAX_X) / 10);
  localparam logic [15:0] c_X4     = 16'((9 * MAX_X) / 10);
  localparam logic [15:0] c_Y_LOW  = 16'((5 * MAX_Y) / 6);
  localparam logic [15:0] c_Y_REST = 16'(MAX_Y / 3);
  localparam logic [15:0] c_DWELL_LAST = 16'(DWELL - 1);
  localparam logic [2:0]  c_WP_LAST    = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  r_wp;
  logic [2:0]  w_wp_nxt;
  logic [1:0]  r_mode;
  logic [1:0]  w_mode_nxt;

  logic [15:0] w_left_x;
  logic [15:0] w_right_x;
  logic [15:0] w_x1_nxt;
  logic [15:0] w_y1_nxt;
  logic [15:0] w_x2_nxt;
  logic [15:0] w_y2_nxt;

  logic [15:0] r_x1;
  logic [15:0] r_y1;
  logic [15:0] r_x2;
  logic [15:0] r_y2;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_waypoint;

  // Next-state logic: dwell counting, waypoint advance, abort and start handling
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wp_nxt    = r_wp;
    w_mode_nxt  = r_mode;
    case (r_state)
      S_IDLE: begin
        // start takes priority over abort here; abort has no meaning when idle
        if (bus.start) begin
          w_state_nxt = S_PLAY;
          w_cnt_nxt   = 16'd0;
          w_wp_nxt    = 3'd0;
          w_mode_nxt  = bus.mode;
        end
      end
      S_PLAY: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 16'd0;
          w_wp_nxt    = 3'd0;
        end else if (r_cnt == c_DWELL_LAST) begin
          w_cnt_nxt = 16'd0;
          if (r_wp == c_WP_LAST) begin
            w_state_nxt = S_FINISH;
            w_wp_nxt    = 3'd0;
          end else begin
            w_wp_nxt = r_wp + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_FINISH: begin
        // start arriving in this cycle is deliberately dropped
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 16'd0;
        w_wp_nxt    = 3'd0;
      end
    endcase
  end

  // Coordinates for the upcoming cycle, so the registered outputs line up with the state
  always_comb begin
    w_left_x  = c_X2;
    w_right_x = c_X2;
    case (w_wp_nxt)
      3'd1, 3'd3: begin
        w_left_x  = c_X1;
        w_right_x = c_X3;
      end
      3'd2: begin
        w_left_x  = c_X0;
        w_right_x = c_X4;
      end
      default: begin
        w_left_x  = c_X2;
        w_right_x = c_X2;
      end
    endcase

    w_x1_nxt = c_X2;
    w_y1_nxt = c_Y_REST;
    w_x2_nxt = c_X2;
    w_y2_nxt = c_Y_REST;
    if (w_state_nxt == S_PLAY) begin
      case (w_mode_nxt)
        2'b00: begin
          w_x1_nxt = w_left_x;
          w_y1_nxt = c_Y_LOW;
          w_x2_nxt = w_right_x;
          w_y2_nxt = c_Y_LOW;
        end
        2'b01: begin
          w_x1_nxt = w_left_x;
          w_y1_nxt = c_Y_LOW;
        end
        2'b10: begin
          w_x2_nxt = w_right_x;
          w_y2_nxt = c_Y_LOW;
        end
        default: begin
          // static pose: both hands lowered at the centre strip
          w_y1_nxt = c_Y_LOW;
          w_y2_nxt = c_Y_LOW;
        end
      endcase
    end
  end

  // State and registered outputs; reset returns everything to the rest pose
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_wp       <= 3'd0;
      r_mode     <= 2'b00;
      r_x1       <= c_X2;
      r_y1       <= c_Y_REST;
      r_x2       <= c_X2;
      r_y2       <= c_Y_REST;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_waypoint <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wp       <= w_wp_nxt;
      r_mode     <= w_mode_nxt;
      r_x1       <= w_x1_nxt;
      r_y1       <= w_y1_nxt;
      r_x2       <= w_x2_nxt;
      r_y2       <= w_y2_nxt;
      r_busy     <= (w_state_nxt == S_PLAY);
      r_done     <= (w_state_nxt == S_FINISH);
      r_waypoint <= (w_state_nxt == S_PLAY) ? w_wp_nxt : 3'd0;
    end
  end

  assign bus.x1       = r_x1;
  assign bus.y1       = r_y1;
  assign bus.x2       = r_x2;
  assign bus.y2       = r_y2;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.waypoint = r_waypoint;

endmodule
`default_nettype wire

// File: tb/tb_gesture_path_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_gesture_path_gen
// Description : Directed self-checking bench for gesture_path_gen
//               (DWELL=4 main instance, DWELL=1 secondary instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gesture_path_gen;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  gesture_path_gen_if bus  ();
  gesture_path_gen_if bus1 ();

  gesture_path_gen #(.MAX_X(15), .MAX_Y(15), .DWELL(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  gesture_path_gen #(.MAX_X(15), .MAX_Y(15), .DWELL(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Observed {x1, y1, x2, y2, busy, done, waypoint}
  logic [68:0] obs;
  logic [68:0] obs1;
  assign obs  = {bus.x1, bus.y1, bus.x2, bus.y2, bus.busy, bus.done, bus.waypoint};
  assign obs1 = {bus1.x1, bus1.y1, bus1.x2, bus1.y2, bus1.busy, bus1.done, bus1.waypoint};

  logic [15:0] lx [5] = '{16'd7, 16'd4, 16'd1, 16'd4, 16'd7};
  logic [15:0] rx [5] = '{16'd7, 16'd10, 16'd13, 16'd10, 16'd7};

  // Build an expected output vector
  function automatic logic [68:0] vec(input logic [15:0] x1, input logic [15:0] y1,
                                      input logic [15:0] x2, input logic [15:0] y2,
                                      input logic busy, input logic done,
                                      input logic [2:0] wp);
    return {x1, y1, x2, y2, busy, done, wp};
  endfunction

  logic [68:0] REST;
  logic [68:0] DONE_V;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [68:0] e;
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 2'b00;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.mode = 2'b00;
    tick(); tick();
    e = REST;
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_state got %h expected %h", obs, e);
    end
    n_cmp++;
    if (obs1 !== e) begin
      n_err++;
      $display("FAIL reset_state_d1 got %h expected %h", obs1, e);
    end
    reset = 1'b0;
    tick();
  endtask

  // Full path in a given mode; mode input is flipped after start to prove it is latched
  task automatic test_path(input logic [1:0] m);
    logic [68:0] e;
    int k;
    bus.mode = m; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.mode = ~m;
    for (int c = 1; c <= 20; c++) begin
      k = (c - 1) / 4;
      e = vec((m == 2'b00 || m == 2'b01) ? lx[k] : 16'd7,
              (m != 2'b10) ? 16'd12 : 16'd5,
              (m == 2'b00 || m == 2'b10) ? rx[k] : 16'd7,
              (m != 2'b01) ? 16'd12 : 16'd5,
              1'b1, 1'b0, 3'(k));
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL path_m%0d cycle %0d got %h expected %h", m, c, obs, e);
      end
      tick();
    end
    e = DONE_V;
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL path_done_m%0d got %h expected %h", m, obs, e);
    end
    tick();
    e = REST;
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL path_after_m%0d got %h expected %h", m, obs, e);
    end
    bus.mode = 2'b00;
  endtask

  task automatic test_abort();
    logic [68:0] e;
    bus.mode = 2'b00; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    e = vec(16'd1, 16'd12, 16'd13, 16'd12, 1'b1, 1'b0, 3'd2);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL abort_pre got %h expected %h", obs, e);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    e = REST;
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL abort_rest got %h expected %h", obs, e);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    e = vec(16'd7, 16'd12, 16'd7, 16'd12, 1'b1, 1'b0, 3'd0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL abort_restart got %h expected %h", obs, e);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    // abort while idle must be inert; start+abort together in idle: start wins
    bus.abort = 1'b1;
    tick();
    e = REST;
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL abort_idle got %h expected %h", obs, e);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    e = vec(16'd7, 16'd12, 16'd7, 16'd12, 1'b1, 1'b0, 3'd0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL start_abort_together got %h expected %h", obs, e);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
  endtask

  task automatic test_start_held();
    logic [68:0] e;
    bus.mode = 2'b00; bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 20; c++) begin
      e = vec(lx[(c - 1) / 4], 16'd12, rx[(c - 1) / 4], 16'd12, 1'b1, 1'b0, 3'((c - 1) / 4));
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL held_path cycle %0d got %h expected %h", c, obs, e);
      end
      tick();
    end
    e = DONE_V;
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL held_done got %h expected %h", obs, e);
    end
    tick();
    e = REST;
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL held_finish_start_dropped got %h expected %h", obs, e);
    end
    tick();
    bus.start = 1'b0;
    e = vec(16'd7, 16'd12, 16'd7, 16'd12, 1'b1, 1'b0, 3'd0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL held_second_path got %h expected %h", obs, e);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [68:0] e;
    bus.mode = 2'b00; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (12) tick();
    e = vec(16'd4, 16'd12, 16'd10, 16'd12, 1'b1, 1'b0, 3'd3);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_mid_pre got %h expected %h", obs, e);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e = REST;
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_mid got %h expected %h", obs, e);
    end
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_mid_stays_idle got %h expected %h", obs, e);
    end
  endtask

  task automatic test_dwell1();
    logic [68:0] e;
    bus1.mode = 2'b00; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      e = vec(lx[c - 1], 16'd12, rx[c - 1], 16'd12, 1'b1, 1'b0, 3'(c - 1));
      n_cmp++;
      if (obs1 !== e) begin
        n_err++;
        $display("FAIL dwell1 cycle %0d got %h expected %h", c, obs1, e);
      end
      tick();
    end
    e = DONE_V;
    n_cmp++;
    if (obs1 !== e) begin
      n_err++;
      $display("FAIL dwell1_done got %h expected %h", obs1, e);
    end
    tick();
    e = REST;
    n_cmp++;
    if (obs1 !== e) begin
      n_err++;
      $display("FAIL dwell1_after got %h expected %h", obs1, e);
    end
  endtask

  initial begin
    REST   = vec(16'd7, 16'd5, 16'd7, 16'd5, 1'b0, 1'b0, 3'd0);
    DONE_V = vec(16'd7, 16'd5, 16'd7, 16'd5, 1'b0, 1'b1, 3'd0);
    test_reset();
    test_path(2'b00);
    test_path(2'b01);
    test_path(2'b10);
    test_path(2'b11);
    test_abort();
    test_start_held();
    test_reset_mid();
    test_dwell1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
